// File: rtl/ice_clk_rst_mgr.sv
// ice_clk_rst_mgr: supervised iCE40 PLL bring-up, lock qualification, system reset and tick enables
module ice_clk_rst_mgr #(
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int NUM_TICK = 2,
  parameter int DIV_W = 16,
  parameter logic [NUM_TICK*DIV_W-1:0] TICK_DIVS = {16'd12, 16'd3}
) (
  input  logic                REFERENCECLK,
  input  logic                RESET,
  input  logic                PLL_LOCK,
  input  logic                SOFT_RST,
  input  logic                LOST_CLR,
  output logic                PLL_RESETB,
  output logic                SYS_RSTN,
  output logic [NUM_TICK-1:0] TICK,
  output logic                LOCK_LOST,
  output logic [3:0]          RETRY_CNT,
  output logic [1:0]          STATE
);
  typedef enum logic [1:0] {PLL_RST = 2'b00, WAIT_LOCK = 2'b01, STABLE = 2'b10, RUN = 2'b11} state_e;
  localparam int CMAX0 = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CMAX = CMAX0 > LOCK_TIMEOUT ? CMAX0 : LOCK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic [1:0] sync_q;
  logic resetb_q, resetb_d, rstn_q, rstn_d, lost_q, lost_d;
  logic lock_s, run_d;
  assign lock_s = sync_q[1];
  assign run_d = state_d == RUN;
  // LOCK is meaningless while the PLL is held in reset, so the synchroniser is cleared then
  always_ff @(posedge REFERENCECLK or negedge RESET)
    if (!RESET) sync_q <= 2'b00;
    else sync_q <= resetb_q ? {sync_q[0], PLL_LOCK} : 2'b00;
  always_ff @(posedge REFERENCECLK or negedge RESET)
    if (!RESET) begin
      state_q <= PLL_RST;
      cnt_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    retry_d = retry_q;
    if (SOFT_RST) begin
      state_d = PLL_RST;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        PLL_RST:
          if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d = '0;
          end
        WAIT_LOCK:
          if (lock_s) begin
            state_d = STABLE;
            cnt_d = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_d = PLL_RST;
            cnt_d = '0;
            retry_d = retry_q + 4'(retry_q != 4'hf);
          end
        STABLE:
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d = '0;
          end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d = '0;
          end
        RUN: begin
          cnt_d = '0;
          state_d = lock_s ? RUN : PLL_RST;
        end
      endcase
    end
  end
  always_comb begin
    resetb_d = state_d != PLL_RST;
    rstn_d = run_d;
    lost_d = (state_q == RUN && !lock_s) || (lost_q && !LOST_CLR);
  end
  always_ff @(posedge REFERENCECLK or negedge RESET)
    if (!RESET) begin
      resetb_q <= 1'b0;
      rstn_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      resetb_q <= resetb_d;
      rstn_q <= rstn_d;
      lost_q <= lost_d;
    end
  for (genvar i = 0; i < NUM_TICK; i++) begin : g_tick
    localparam logic [DIV_W-1:0] D = TICK_DIVS[i*DIV_W +: DIV_W];
    logic [DIV_W-1:0] tc_q, tc_d;
    logic tick_q, tick_d;
    always_comb begin
      tick_d = run_d && D != '0 && tc_q == D - DIV_W'(1);
      tc_d = (!run_d || tick_d || D == '0) ? '0 : tc_q + DIV_W'(1);
    end
    always_ff @(posedge REFERENCECLK or negedge RESET)
      if (!RESET) begin
        tc_q <= '0;
        tick_q <= 1'b0;
      end else begin
        tc_q <= tc_d;
        tick_q <= tick_d;
      end
    assign TICK[i] = tick_q;
  end
  assign PLL_RESETB = resetb_q;
  assign SYS_RSTN = rstn_q;
  assign LOCK_LOST = lost_q;
  assign RETRY_CNT = retry_q;
  assign STATE = state_q;
endmodule

// File: tb/tb_ice_clk_rst_mgr.sv
// tb_ice_clk_rst_mgr: directed bring-up, retry, lock-loss, glitch, soft/async reset and tick checks
module tb_ice_clk_rst_mgr;
  logic clk = 1'b0;
  logic rst_a, rst_b, lock_a, lock_b, soft_a, clr_a;
  logic resetb_a, rstn_a, lost_a, resetb_b, rstn_b, lost_b;
  logic [1:0] tick_a, tick_b, st_a, st_b;
  logic [3:0] retry_a, retry_b;
  int cyc, passed, total;

  typedef struct {
    int cyc;
    logic resetb;
    logic rstn;
    logic [1:0] st;
    logic [1:0] tick;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  ice_clk_rst_mgr dut_a (
    .REFERENCECLK(clk), .RESET(rst_a), .PLL_LOCK(lock_a), .SOFT_RST(soft_a), .LOST_CLR(clr_a),
    .PLL_RESETB(resetb_a), .SYS_RSTN(rstn_a), .TICK(tick_a), .LOCK_LOST(lost_a),
    .RETRY_CNT(retry_a), .STATE(st_a)
  );

  ice_clk_rst_mgr #(.LOCK_TIMEOUT(100), .TICK_DIVS({16'd0, 16'd1})) dut_b (
    .REFERENCECLK(clk), .RESET(rst_b), .PLL_LOCK(lock_b), .SOFT_RST(1'b0), .LOST_CLR(1'b0),
    .PLL_RESETB(resetb_b), .SYS_RSTN(rstn_b), .TICK(tick_b), .LOCK_LOST(lost_b),
    .RETRY_CNT(retry_b), .STATE(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, " state"}, 32'(st_a), 32'd0);
    check({tag, " resetb"}, 32'(resetb_a), 32'd0);
    check({tag, " rstn"}, 32'(rstn_a), 32'd0);
    check({tag, " tick"}, 32'(tick_a), 32'd0);
    check({tag, " lost"}, 32'(lost_a), 32'd0);
    check({tag, " retry"}, 32'(retry_a), 32'd0);
  endtask

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    lock_a = 1'b1;
    lock_b = 1'b0;
    soft_a = 1'b0;
    clr_a = 1'b0;
    tbl.push_back('{1, 1'b0, 1'b0, 2'd0, 2'b00});
    tbl.push_back('{7, 1'b0, 1'b0, 2'd0, 2'b00});
    tbl.push_back('{8, 1'b1, 1'b0, 2'd1, 2'b00});
    tbl.push_back('{10, 1'b1, 1'b0, 2'd1, 2'b00});
    tbl.push_back('{11, 1'b1, 1'b0, 2'd2, 2'b00});
    tbl.push_back('{26, 1'b1, 1'b0, 2'd2, 2'b00});
    tbl.push_back('{27, 1'b1, 1'b1, 2'd3, 2'b00});
    tbl.push_back('{28, 1'b1, 1'b1, 2'd3, 2'b00});
    tbl.push_back('{29, 1'b1, 1'b1, 2'd3, 2'b01});
    tbl.push_back('{30, 1'b1, 1'b1, 2'd3, 2'b00});
    tbl.push_back('{32, 1'b1, 1'b1, 2'd3, 2'b01});
    tbl.push_back('{37, 1'b1, 1'b1, 2'd3, 2'b00});
    tbl.push_back('{38, 1'b1, 1'b1, 2'd3, 2'b11});
    tbl.push_back('{41, 1'b1, 1'b1, 2'd3, 2'b01});
    tbl.push_back('{49, 1'b1, 1'b1, 2'd3, 2'b00});
    tbl.push_back('{50, 1'b1, 1'b1, 2'd3, 2'b11});
    repeat (3) @(negedge clk);
    check_a_reset("rst");
    check("rst b resetb", 32'(resetb_b), 32'd0);
    check("rst b tick", 32'(tick_b), 32'd0);
    rst_a = 1'b1;
    foreach (tbl[k]) begin
      go(tbl[k].cyc);
      check("tbl resetb", 32'(resetb_a), 32'(tbl[k].resetb));
      check("tbl rstn", 32'(rstn_a), 32'(tbl[k].rstn));
      check("tbl state", 32'(st_a), 32'(tbl[k].st));
      check("tbl tick", 32'(tick_a), 32'(tbl[k].tick));
    end
    lock_a = 1'b0;
    go(52);
    check("drop still run", 32'(st_a), 32'd3);
    check("drop rstn hold", 32'(rstn_a), 32'd1);
    go(53);
    check("drop state", 32'(st_a), 32'd0);
    check("drop rstn", 32'(rstn_a), 32'd0);
    check("drop resetb", 32'(resetb_a), 32'd0);
    check("drop tick", 32'(tick_a), 32'd0);
    check("drop lost", 32'(lost_a), 32'd1);
    lock_a = 1'b1;
    go(61);
    check("reseq resetb", 32'(resetb_a), 32'd1);
    go(79);
    check("reseq rstn early", 32'(rstn_a), 32'd0);
    go(80);
    check("reseq rstn", 32'(rstn_a), 32'd1);
    check("reseq lost sticky", 32'(lost_a), 32'd1);
    go(81);
    clr_a = 1'b1;
    go(82);
    clr_a = 1'b0;
    check("clr lost", 32'(lost_a), 32'd0);
    go(85);
    lock_a = 1'b0;
    go(87);
    check("pre loss lost", 32'(lost_a), 32'd0);
    clr_a = 1'b1;
    go(88);
    clr_a = 1'b0;
    lock_a = 1'b1;
    check("set beats clr", 32'(lost_a), 32'd1);
    check("loss2 state", 32'(st_a), 32'd0);
    go(107);
    lock_a = 1'b0;
    go(108);
    lock_a = 1'b1;
    go(109);
    check("glitch stable", 32'(st_a), 32'd2);
    go(110);
    check("glitch wait", 32'(st_a), 32'd1);
    go(111);
    check("glitch restable", 32'(st_a), 32'd2);
    go(126);
    check("glitch rstn early", 32'(rstn_a), 32'd0);
    go(127);
    check("glitch rstn", 32'(rstn_a), 32'd1);
    check("glitch run", 32'(st_a), 32'd3);
    go(130);
    soft_a = 1'b1;
    go(131);
    soft_a = 1'b0;
    check("soft state", 32'(st_a), 32'd0);
    check("soft resetb", 32'(resetb_a), 32'd0);
    check("soft rstn", 32'(rstn_a), 32'd0);
    check("soft tick", 32'(tick_a), 32'd0);
    check("soft lost kept", 32'(lost_a), 32'd1);
    check("soft retry", 32'(retry_a), 32'd0);
    go(139);
    check("soft reseq resetb", 32'(resetb_a), 32'd1);
    go(157);
    check("soft reseq rstn early", 32'(rstn_a), 32'd0);
    go(158);
    check("soft reseq rstn", 32'(rstn_a), 32'd1);
    go(165);
    #2 rst_a = 1'b0;
    #1 check_a_reset("async");
    @(negedge clk);
    rst_a = 1'b1;
    cyc = 0;
    go(7);
    check("async reseq resetb low", 32'(resetb_a), 32'd0);
    go(8);
    check("async reseq resetb", 32'(resetb_a), 32'd1);
    rst_b = 1'b1;
    cyc = 0;
    go(107);
    check("b resetb 107", 32'(resetb_b), 32'd1);
    check("b retry 107", 32'(retry_b), 32'd0);
    go(108);
    check("b resetb 108", 32'(resetb_b), 32'd0);
    check("b retry 108", 32'(retry_b), 32'd1);
    check("b state 108", 32'(st_b), 32'd0);
    go(115);
    check("b resetb 115", 32'(resetb_b), 32'd0);
    go(116);
    check("b resetb 116", 32'(resetb_b), 32'd1);
    check("b state 116", 32'(st_b), 32'd1);
    go(215);
    check("b resetb 215", 32'(resetb_b), 32'd1);
    go(216);
    check("b resetb 216", 32'(resetb_b), 32'd0);
    check("b retry 216", 32'(retry_b), 32'd2);
    go(1619);
    check("b retry 1619", 32'(retry_b), 32'd14);
    go(1620);
    check("b retry 1620", 32'(retry_b), 32'd15);
    go(1728);
    check("b retry sat", 32'(retry_b), 32'd15);
    check("b rstn low", 32'(rstn_b), 32'd0);
    check("b resetb 1728", 32'(resetb_b), 32'd0);
    lock_b = 1'b1;
    go(1754);
    check("b rstn early", 32'(rstn_b), 32'd0);
    check("b tick early", 32'(tick_b), 32'd0);
    go(1755);
    check("b rstn", 32'(rstn_b), 32'd1);
    check("b tick first", 32'(tick_b), 32'b01);
    go(1760);
    check("b tick d1 d0", 32'(tick_b), 32'b01);
    check("b retry kept", 32'(retry_b), 32'd15);
    check("b lost", 32'(lost_b), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
